// File: rtl/audio_sample_pacer.sv
// audio_sample_pacer: derives the HDMI audio sample clock from the pixel
// clock with a fractional phase accumulator, so the long-run rate is exact.
// Once per sample period it pops one frame from the audio FIFO (read
// latency 1) and hands it to the hdmi core. On underrun the last frame is
// held (or zeroed when muted) and the event is counted.
//
// Ports:
//   clk_pixel        sole clock
//   reset_n          synchronous, active-low reset
//   mute             1: output zeros; FIFO is still drained at the sample rate
//   fifo_empty       audio FIFO empty flag
//   fifo_rden        one-cycle FIFO read strobe
//   fifo_q           FIFO data, valid one cycle after fifo_rden
//   audio_clk        sample clock, ~50% duty, falls the cycle after a tick
//   sample_word      current frame, channel 0 in the LSBs
//   sample_strobe    high in the cycle whose closing edge loads sample_word
//   underrun_sticky  set by any underrun, cleared only by reset
//   underrun_count   saturating count of underrun ticks
module audio_sample_pacer #(
    parameter int CLK_HZ         = 74250000,
    parameter int SAMPLE_RATE    = 48000,
    parameter int CHANNELS       = 2,
    parameter int SAMPLE_WIDTH   = 16,
    parameter int UNDERRUN_WIDTH = 16
) (
    input  logic                             clk_pixel,
    input  logic                             reset_n,
    input  logic                             mute,
    input  logic                             fifo_empty,
    output logic                             fifo_rden,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0] fifo_q,
    output logic                             audio_clk,
    output logic [CHANNELS*SAMPLE_WIDTH-1:0] sample_word,
    output logic                             sample_strobe,
    output logic                             underrun_sticky,
    output logic [UNDERRUN_WIDTH-1:0]        underrun_count
);

    localparam int PW = $clog2(CLK_HZ) + 1;

    localparam logic [PW-1:0] INC  = PW'(SAMPLE_RATE);
    localparam logic [PW-1:0] LIM  = PW'(CLK_HZ);
    localparam logic [PW-1:0] HALF = PW'(CLK_HZ / 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    // A period of at least four cycles guarantees no tick lands while a
    // read is still in flight.
    if (SAMPLE_RATE <= 0 || 4 * SAMPLE_RATE > CLK_HZ) begin : g_rate_check
        $error("audio_sample_pacer: need 0 < 4*SAMPLE_RATE <= CLK_HZ");
    end

    logic [PW-1:0] phase;
    logic [PW-1:0] sum;
    logic [PW-1:0] phase_nxt;
    logic          tick;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          under_set;
    logic          under;

    always_comb begin
        sum       = phase + INC;
        tick      = (sum >= LIM);
        phase_nxt = tick ? sum - LIM : sum;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (tick && !fifo_empty) state_nxt = S_READ;
            S_READ:  state_nxt = fifo_empty ? S_IDLE : S_LATCH;
            S_LATCH: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign fifo_rden = (state == S_READ) && !fifo_empty;

    // A frame that vanished between the tick and the read slot is treated
    // like an ordinary underrun rather than latching stale FIFO data.
    assign under_set = ((state == S_IDLE) && tick && fifo_empty)
                    || ((state == S_READ) && fifo_empty);

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            phase           <= '0;
            state           <= S_IDLE;
            under           <= 1'b0;
            audio_clk       <= 1'b0;
            sample_word     <= '0;
            sample_strobe   <= 1'b0;
            underrun_sticky <= 1'b0;
            underrun_count  <= '0;
        end else begin
            phase         <= phase_nxt;
            audio_clk     <= (phase_nxt >= HALF);
            state         <= state_nxt;
            under         <= under_set;
            sample_strobe <= under_set || fifo_rden;
            if (state == S_LATCH) begin
                sample_word <= mute ? '0 : fifo_q;
            end else if (under) begin
                if (mute) sample_word <= '0;
                underrun_sticky <= 1'b1;
                if (underrun_count != '1)
                    underrun_count <= underrun_count + UNDERRUN_WIDTH'(1);
            end
        end
    end

endmodule
